// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, FSM state type and window helper for the fetch stage.
//   RESET_PC_DEFAULT - PC after reset and sequential wrap target
//   NOP              - instruction word used for pipeline bubbles
//   fetch_state_t    - RUN (normal fetch) / BUBBLE (one cycle after a redirect)
//   window_end()     - first address past the ROM fetch window
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } fetch_state_t;

  // Computed wide; callers truncate to their datapath width (modulo arithmetic).
  function automatic logic [63:0] window_end(input logic [63:0] base, input int unsigned depth);
    return base + (64'(depth) << 2);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch stage control, ROM and IF/ID signals.
//   master - pipeline/ROM side: drives stall, redirects and ROM data, observes IF/ID
//   slave  - fetch_unit side
interface fetch_unit_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned COUNT_WIDTH = 16
);
  import fetch_pkg::*;

  logic                   Stall_i;
  logic                   Branch_Taken_i;
  logic [DATA_WIDTH-1:0]  Branch_Target_i;
  logic                   Jump_i;
  logic [DATA_WIDTH-1:0]  Jump_Target_i;
  logic [DATA_WIDTH-1:0]  Instruction_i;
  logic [DATA_WIDTH-1:0]  Address_o;
  logic [DATA_WIDTH-1:0]  Instruction_o;
  logic [DATA_WIDTH-1:0]  PC_Plus4_o;
  logic                   Valid_o;
  logic                   Addr_Error_o;
  logic [COUNT_WIDTH-1:0] Fetch_Count_o;

  modport master (
    output Stall_i, Branch_Taken_i, Branch_Target_i, Jump_i, Jump_Target_i, Instruction_i,
    input  Address_o, Instruction_o, PC_Plus4_o, Valid_o, Addr_Error_o, Fetch_Count_o
  );

  modport slave (
    input  Stall_i, Branch_Taken_i, Branch_Target_i, Jump_i, Jump_Target_i, Instruction_i,
    output Address_o, Instruction_o, PC_Plus4_o, Valid_o, Addr_Error_o, Fetch_Count_o
  );

endinterface

// File: rtl/pc_register.sv
// pc_register: program counter register with load enable.
//   clk   - rising-edge clock
//   reset - asynchronous active-high, loads RESET_PC
//   load  - capture d on the next edge
//   d     - next PC
//   q     - current PC
module pc_register import fetch_pkg::*; #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction-fetch stage with IF/ID pipeline register.
//   clk   - rising-edge clock
//   reset - asynchronous active-high
//   bus   - fetch_unit_if.slave: stall/branch/jump controls, ROM data in, ROM address out,
//           IF/ID instruction, PC+4, valid, sticky address error and fetch counter.
module fetch_unit import fetch_pkg::*; #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = DATA_WIDTH'(RESET_PC_DEFAULT),
  parameter int unsigned           COUNT_WIDTH  = 16
) (
  input logic         clk,
  input logic         reset,
  fetch_unit_if.slave bus
);

  localparam logic [DATA_WIDTH-1:0] WinEnd =
      DATA_WIDTH'(window_end(64'(RESET_PC), MEMORY_DEPTH));

  logic [DATA_WIDTH-1:0]  pc_q, pc_d, pc_plus4, target;
  logic                   pc_en, redirect, target_ok, capture;
  logic [DATA_WIDTH-1:0]  instr_q, plus4_q;
  logic                   valid_q, err_q;
  logic [COUNT_WIDTH-1:0] count_q;
  fetch_state_t           state_q, state_d;

  assign pc_plus4 = pc_q + DATA_WIDTH'(4);
  assign redirect = bus.Branch_Taken_i | bus.Jump_i;
  // Branch is the older instruction, so its target is the only one that matters.
  assign target   = bus.Branch_Taken_i ? bus.Branch_Target_i : bus.Jump_Target_i;
  assign target_ok = (target[1:0] == 2'b00) && (target >= RESET_PC) && (target < WinEnd);
  assign capture  = !redirect && !bus.Stall_i;

  always_comb begin
    pc_en = 1'b0;
    pc_d  = pc_q;
    if (redirect) begin
      // An illegal target leaves the PC where it is.
      pc_en = target_ok;
      pc_d  = target;
    end else if (!bus.Stall_i) begin
      pc_en = 1'b1;
      pc_d  = (pc_plus4 == WinEnd) ? RESET_PC : pc_plus4;
    end
  end

  pc_register #(
    .DATA_WIDTH(DATA_WIDTH),
    .RESET_PC  (RESET_PC)
  ) u_pc (
    .clk  (clk),
    .reset(reset),
    .load (pc_en),
    .d    (pc_d),
    .q    (pc_q)
  );

  // BUBBLE marks the cycle where IF/ID holds the squashed slot after a redirect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:    if (redirect) state_d = BUBBLE;
      BUBBLE: state_d = redirect ? BUBBLE : RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      instr_q <= DATA_WIDTH'(NOP);
      plus4_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (redirect && !target_ok) begin
        err_q <= 1'b1;
      end
      if (redirect) begin
        // PC+4 is left untouched on a squash.
        instr_q <= DATA_WIDTH'(NOP);
        valid_q <= 1'b0;
      end else if (capture) begin
        instr_q <= bus.Instruction_i;
        plus4_q <= pc_plus4;
        valid_q <= 1'b1;
        if (count_q != '1) begin
          count_q <= count_q + COUNT_WIDTH'(1);
        end
      end
    end
  end

  assign bus.Address_o     = pc_q;
  assign bus.Instruction_o = instr_q;
  assign bus.PC_Plus4_o    = plus4_q;
  assign bus.Valid_o       = valid_q;
  assign bus.Addr_Error_o  = err_q;
  assign bus.Fetch_Count_o = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. The driver applies stimulus at the falling
// edge and pushes the expected post-edge IF/ID state from a behavioural model; a monitor pops
// and compares after every rising edge.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned CW    = 16;
  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam logic [31:0] WEND  = BASE + 32'(4 * DEPTH);

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] p4;
    logic        valid;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] rom [DEPTH];
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Behavioural model of the architectural state.
  logic [31:0] m_pc, m_instr, m_p4;
  logic        m_valid, m_err;
  int          m_cnt;

  fetch_unit_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

  fetch_unit #(
    .DATA_WIDTH  (DW),
    .MEMORY_DEPTH(DEPTH),
    .RESET_PC    (BASE),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Combinational ROM: word index within the fetch window.
  assign bus.Instruction_i = rom[6'((bus.Address_o - BASE) >> 2)];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".addr"},  bus.Address_o, e.addr);
    check({tag, ".instr"}, bus.Instruction_o, e.instr);
    check({tag, ".p4"},    bus.PC_Plus4_o, e.p4);
    check({tag, ".valid"}, 32'(bus.Valid_o), 32'(e.valid));
    check({tag, ".err"},   32'(bus.Addr_Error_o), 32'(e.err));
    check({tag, ".cnt"},   32'(bus.Fetch_Count_o), 32'(e.cnt));
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.addr  = m_pc;
    e.instr = m_instr;
    e.p4    = m_p4;
    e.valid = m_valid;
    e.err   = m_err;
    e.cnt   = 16'(m_cnt);
    return e;
  endfunction

  task automatic model_reset();
    m_pc = BASE; m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0; m_err = 1'b0; m_cnt = 0;
  endtask

  // Apply one cycle of stimulus (called at a falling edge) and predict the next edge.
  task automatic step(input logic st, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt);
    logic [31:0] t;
    bus.Stall_i = st; bus.Branch_Taken_i = br; bus.Branch_Target_i = bt;
    bus.Jump_i = jp; bus.Jump_Target_i = jt;
    if (br || jp) begin
      t = br ? bt : jt;
      if (t % 4 == 0 && t >= BASE && t < WEND) m_pc = t;
      else m_err = 1'b1;
      m_instr = 32'h0;
      m_valid = 1'b0;
    end else if (!st) begin
      m_instr = rom[(m_pc - BASE) / 4];
      m_p4    = m_pc + 4;
      m_valid = 1'b1;
      if (m_cnt < 65535) m_cnt++;
      m_pc = (m_pc + 4 == WEND) ? BASE : m_pc + 4;
    end
    exp_q.push_back(model_snapshot());
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Monitor: one expected record per rising edge once stimulus has started.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check_all("sb", exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t rst_e;
    logic [31:0] held;
    logic [31:0] t;
    int r;
    rst_e.addr = BASE; rst_e.instr = 32'h0; rst_e.p4 = 32'h0;
    rst_e.valid = 1'b0; rst_e.err = 1'b0; rst_e.cnt = 16'h0;

    for (int i = 0; i < int'(DEPTH); i++) rom[i] = $urandom;
    rom[0] = 32'h2008_FFFF;
    rom[1] = 32'h2009_0010;
    rom[2] = 32'h200A_000A;
    rom[6] = 32'h016A_9020;
    bus.Stall_i = 1'b0; bus.Branch_Taken_i = 1'b0; bus.Branch_Target_i = 32'h0;
    bus.Jump_i = 1'b0; bus.Jump_Target_i = 32'h0;

    #1 reset = 1'b1;
    #1 check_all("reset", rst_e);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Sequential fetch, then a two-cycle stall at 0x400008.
    idle(2);
    check("seq_addr", bus.Address_o, 32'h0040_0008);
    check("seq_instr", bus.Instruction_o, 32'h2009_0010);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("stall_addr", bus.Address_o, 32'h0040_0008);
    check("stall_instr", bus.Instruction_o, 32'h2009_0010);
    idle(1);
    check("post_stall_instr", bus.Instruction_o, 32'h200A_000A);
    check("post_stall_addr", bus.Address_o, 32'h0040_000C);
    check("post_stall_cnt", 32'(bus.Fetch_Count_o), 32'd3);

    // Branch and jump together: branch wins.
    idle(2);
    step(1'b0, 1'b1, 32'h0040_0018, 1'b1, 32'h0040_0004);
    check("br_addr", bus.Address_o, 32'h0040_0018);
    check("br_bubble_valid", 32'(bus.Valid_o), 32'd0);
    check("br_bubble_instr", bus.Instruction_o, 32'h0);
    idle(1);
    check("br_target_instr", bus.Instruction_o, 32'h016A_9020);

    // End-of-window wrap.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_00FC);
    check("wrap_pre_addr", bus.Address_o, 32'h0040_00FC);
    idle(1);
    check("wrap_addr", bus.Address_o, 32'h0040_0000);
    check("wrap_p4", bus.PC_Plus4_o, 32'h0040_0100);
    check("wrap_err", 32'(bus.Addr_Error_o), 32'd0);

    // Illegal redirects: misaligned, then outside the window.
    held = bus.Address_o;
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0006);
    check("misalign_addr", bus.Address_o, held);
    check("misalign_err", 32'(bus.Addr_Error_o), 32'd1);
    check("misalign_valid", 32'(bus.Valid_o), 32'd0);
    idle(1);
    held = bus.Address_o;
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0050_0000);
    check("outside_addr", bus.Address_o, held);
    check("outside_err", 32'(bus.Addr_Error_o), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) t = BASE + 4 * $urandom_range(0, DEPTH - 1);
      else if (r < 9) t = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
      else t = $urandom;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, t,
           $urandom_range(0, 9) == 0, BASE + 4 * $urandom_range(0, DEPTH - 1));
    end

    // Asynchronous reset in the middle of a bubble cycle.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0020);
    bus.Jump_i = 1'b0;
    #2 reset = 1'b1;
    #1 check_all("async_reset", rst_e);
    #1 reset = 1'b0;
    model_reset();
    idle(1);
    check("after_reset_instr", bus.Instruction_o, 32'h2008_FFFF);
    idle(2);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
